// File: rtl/inert_spi_slave_pkg.sv
// Shared constants and state encoding for the inertial-sensor SPI responder.
package inert_slv_pkg;
  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHOAMI    = 7'h0F;
  localparam logic [6:0] ADDR_CTRL1_XL  = 7'h10;
  localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
  localparam logic [6:0] ADDR_PTCH_L    = 7'h22;
  localparam logic [6:0] ADDR_PTCH_H    = 7'h23;
  localparam logic [6:0] ADDR_FRMERR    = 7'h7F;

  typedef enum logic [1:0] {IDLE, CMD, DATA} slv_state_e;

  function automatic logic is_ptch_addr(input logic [6:0] a);
    return (a == ADDR_PTCH_L) || (a == ADDR_PTCH_H);
  endfunction
endpackage

// File: rtl/inert_spi_slave_if.sv
// Master-driven SPI lines into the responder.
interface inert_spi_slave_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;

  modport master (output SS_n, output SCLK, output MOSI);
  modport slave  (input SS_n, input SCLK, input MOSI);
endinterface

// File: rtl/inert_spi_slave_sync.sv
// Multi-flop synchronizer with rise/fall strobes taken from the synchronized value.
module spi_slv_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  // [STAGES-1:0] is the sync chain, [STAGES] holds the previous synchronized value
  logic [STAGES:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {(STAGES+1){RST_VAL}};
    else        sync_q <= {sync_q[STAGES-1:0], d_i};
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1] & ~sync_q[STAGES];
  assign fall_o = ~sync_q[STAGES-1] &  sync_q[STAGES];
endmodule

// File: rtl/inert_spi_slave.sv
// SPI responder emulating the inertial sensor: 16-bit frames, small register file, pitch INT.
// Optional frame-error counter at 0x7F: define INERT_SLV_FRMERR_EN.
module inert_spi_slave import inert_slv_pkg::*; #(
  parameter logic [7:0] WHOAMI_VAL  = 8'h6A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  inert_spi_slave_if.slave   spi,
  output wire                MISO,
  input  logic               smpl_vld,
  input  logic [15:0]        ptch_in,
  output logic               INT
);
  localparam logic [4:0] FULL_CNT = 5'(FRAME_BITS);

  logic ss_s, ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_s;

  spi_slv_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk, .rst_n, .d_i(spi.SS_n), .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall));
  spi_slv_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk, .rst_n, .d_i(spi.SCLK), .q_o(), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_slv_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk, .rst_n, .d_i(spi.MOSI), .q_o(mosi_s), .rise_o(), .fall_o());

  slv_state_e  state_q, state_d;
  logic [4:0]  bitcnt_q;
  logic [7:0]  rx_q, tx_q;
  logic [6:0]  addr_q;
  logic        rd_q;
  logic [7:0]  int1_q, ctrl1_q, ctrl2_q;
  logic [15:0] ptch_q, pend_q;
  logic        pend_vld_q, int_q;
`ifdef INERT_SLV_FRMERR_EN
  logic [7:0]  frmerr_q;
  logic        abort;
`endif

  logic       ld_tx, frame_end, full, wr_cmt, int_clr, int_set, smpl_ok, ptch_busy;
  logic [7:0] rdata;

  always_comb begin
    state_d = state_q;
    ld_tx   = 1'b0;
    unique case (state_q)
      IDLE: if (ss_fall) state_d = CMD;
      CMD: begin
        if (bitcnt_q == 5'd8) begin
          state_d = DATA;
          ld_tx   = 1'b1;
        end
      end
      DATA: state_d = DATA;
      default: state_d = IDLE;
    endcase
    if (ss_rise && state_q != IDLE) state_d = IDLE;
  end

  // rx_q holds the command byte at count 8, the data byte at count 16
  always_comb begin
    rdata = 8'h00;
    case (rx_q[6:0])
      ADDR_INT1_CTRL: rdata = int1_q;
      ADDR_WHOAMI:    rdata = WHOAMI_VAL;
      ADDR_CTRL1_XL:  rdata = ctrl1_q;
      ADDR_CTRL2_G:   rdata = ctrl2_q;
      ADDR_PTCH_L:    rdata = ptch_q[7:0];
      ADDR_PTCH_H:    rdata = ptch_q[15:8];
`ifdef INERT_SLV_FRMERR_EN
      ADDR_FRMERR:    rdata = frmerr_q;
`endif
      default:        rdata = 8'h00;
    endcase
  end

  assign frame_end = ss_rise && (state_q != IDLE);
  assign full      = (bitcnt_q == FULL_CNT);
  assign wr_cmt    = frame_end && full && !rd_q;
  assign int_clr   = frame_end && full && rd_q && (addr_q == ADDR_PTCH_H);
  assign smpl_ok   = smpl_vld && (int1_q != 8'h00);
  // The frame-end clk itself is not busy, so a held sample lands exactly then
  assign ptch_busy = (state_q == DATA) && is_ptch_addr(addr_q) && !ss_rise;
  assign int_set   = !ptch_busy && (smpl_ok || pend_vld_q);
`ifdef INERT_SLV_FRMERR_EN
  assign abort     = frame_end && !full && (bitcnt_q != 5'd0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      int1_q     <= '0;
      ctrl1_q    <= '0;
      ctrl2_q    <= '0;
      ptch_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE) begin
        rx_q     <= '0;
        bitcnt_q <= '0;
      end else if (sclk_rise && bitcnt_q != 5'h1F) begin
        rx_q     <= {rx_q[6:0], mosi_s};
        bitcnt_q <= bitcnt_q + 5'd1;
      end

      // the fall between rise 8 and 9 must not shift: tx[7] is still being presented
      if (ld_tx) begin
        tx_q   <= rx_q[7] ? rdata : 8'h00;
        addr_q <= rx_q[6:0];
        rd_q   <= rx_q[7];
      end else if (state_q == DATA && sclk_fall && bitcnt_q >= 5'd9) begin
        tx_q <= {tx_q[6:0], 1'b0};
      end

      if (wr_cmt) begin
        case (addr_q)
          ADDR_INT1_CTRL: int1_q  <= rx_q;
          ADDR_CTRL1_XL:  ctrl1_q <= rx_q;
          ADDR_CTRL2_G:   ctrl2_q <= rx_q;
          default: ;
        endcase
      end

      if (smpl_ok && ptch_busy) begin
        pend_q     <= ptch_in;
        pend_vld_q <= 1'b1;
      end else if (smpl_ok) begin
        ptch_q     <= ptch_in;
        pend_vld_q <= 1'b0;
      end else if (pend_vld_q && !ptch_busy) begin
        ptch_q     <= pend_q;
        pend_vld_q <= 1'b0;
      end

      if (int_set)      int_q <= 1'b1;
      else if (int_clr) int_q <= 1'b0;
    end
  end

`ifdef INERT_SLV_FRMERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                frmerr_q <= '0;
    else if (wr_cmt && addr_q == ADDR_FRMERR)  frmerr_q <= '0;
    else if (abort && frmerr_q != 8'hFF)       frmerr_q <= frmerr_q + 8'd1;
  end
`endif

  assign MISO = ss_s ? 1'bz : ((state_q == DATA) ? tx_q[7] : 1'b0);
  assign INT  = int_q;
endmodule

// File: tb/tb_inert_spi_slave.sv
// Self-checking bench for inert_spi_slave: vector table plus multi-frame corner sequences.
module tb_inert_spi_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        smpl_vld = 1'b0;
  logic [15:0] ptch_in = '0;
  logic        INT;
  wire         MISO;

  always #5 clk = ~clk;

  inert_spi_slave_if spi();
  pullup (MISO);

  inert_spi_slave #(.WHOAMI_VAL(8'h6A), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi), .MISO(MISO),
    .smpl_vld(smpl_vld), .ptch_in(ptch_in), .INT(INT));

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] w;
    logic [7:0]  rd;
    logic        intv;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic m);
    spi.SCLK = 1'b0; spi.MOSI = b; clks(10);
    m = MISO;
    spi.SCLK = 1'b1; clks(10);
  endtask

  task automatic frame(input logic [15:0] w, input int nbits, output logic [15:0] got);
    logic m;
    got = '0;
    spi.SS_n = 1'b0; clks(10);
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[15-i], m);
      got[15-i] = m;
    end
    spi.SS_n = 1'b1; clks(10);
  endtask

  task automatic xfer(input string nm, input logic [15:0] w, input logic [7:0] exp);
    logic [15:0] got;
    logic [7:0]  e;
    exp_q.push_back(exp);
    frame(w, 16, got);
    chk({nm, " cmd MISO"}, {8'h00, got[15:8]}, 16'h0000);
    e = exp_q.pop_front();
    chk(nm, {8'h00, got[7:0]}, {8'h00, e});
  endtask

  task automatic pulse(input logic [15:0] p);
    ptch_in = p; smpl_vld = 1'b1; clks(1); smpl_vld = 1'b0;
  endtask

  initial begin
    logic [15:0] got;
    logic m;
    logic [7:0] frm_exp;
    spi.SS_n = 1'b1; spi.SCLK = 1'b1; spi.MOSI = 1'b0;

    tbl[0] = '{16'h8F00, 8'h6A, 1'b0};
    tbl[1] = '{16'h0D02, 8'h00, 1'b0};
    tbl[2] = '{16'h8D00, 8'h02, 1'b0};
    tbl[3] = '{16'h0F55, 8'h00, 1'b0};
    tbl[4] = '{16'h8F00, 8'h6A, 1'b0};
    tbl[5] = '{16'h9000, 8'h00, 1'b0};
    tbl[6] = '{16'h1155, 8'h00, 1'b0};
    tbl[7] = '{16'h9100, 8'h55, 1'b0};
    tbl[8] = '{16'hA500, 8'h00, 1'b0};
    tbl[9] = '{16'hFF00, 8'h00, 1'b0};

    clks(3);
    chk("reset INT", {15'h0, INT}, 16'h0);
    chk("reset MISO hiz", {15'h0, MISO}, 16'h1);
    rst_n = 1'b1; clks(5);

    for (int i = 0; i < 10; i++) begin
      xfer($sformatf("vec%0d", i), tbl[i].w, tbl[i].rd);
      chk($sformatf("vec%0d INT", i), {15'h0, INT}, {15'h0, tbl[i].intv});
    end
    chk("idle MISO hiz", {15'h0, MISO}, 16'h1);

    pulse(16'hFE37); clks(2);
    chk("smpl INT set", {15'h0, INT}, 16'h1);
    xfer("ptch_l", 16'hA200, 8'h37);
    chk("ptch_l INT held", {15'h0, INT}, 16'h1);
    xfer("ptch_h", 16'hA300, 8'hFE);
    chk("ptch_h INT clr", {15'h0, INT}, 16'h0);

    fork
      xfer("coh ptch_h", 16'hA300, 8'hFE);
      begin clks(10 + 20*11); pulse(16'h1234); end
    join
    chk("set wins INT", {15'h0, INT}, 16'h1);
    xfer("coh ptch_l new", 16'hA200, 8'h34);
    chk("coh INT held", {15'h0, INT}, 16'h1);
    xfer("coh ptch_h new", 16'hA300, 8'h12);
    chk("coh INT clr", {15'h0, INT}, 16'h0);

    xfer("int1 off", 16'h0D00, 8'h00);
    pulse(16'h5555); clks(3);
    chk("ignored smpl INT", {15'h0, INT}, 16'h0);
    xfer("ignored smpl ptch", 16'hA200, 8'h34);
    xfer("int1 on", 16'h0D02, 8'h00);

    frame(16'h1099, 10, got);
    spi.SS_n = 1'b0; clks(10); spi.SS_n = 1'b1; clks(10);
    xfer("abort ctrl1", 16'h9000, 8'h00);
`ifdef INERT_SLV_FRMERR_EN
    frm_exp = 8'h01;
`else
    frm_exp = 8'h00;
`endif
    xfer("frmerr count", 16'hFF00, frm_exp);
    xfer("frmerr clr wr", 16'h7F00, 8'h00);
    xfer("frmerr cleared", 16'hFF00, 8'h00);

    xfer("ctrl2 pre", 16'h11AA, 8'h00);
    pulse(16'h0BAD); clks(2);
    chk("pre-reset INT", {15'h0, INT}, 16'h1);
    spi.SS_n = 1'b0; clks(10);
    for (int i = 0; i < 5; i++) send_bit(1'(16'h1133 >> (15 - i)), m);
    spi.SCLK = 1'b0; clks(3);
    rst_n = 1'b0; clks(2);
    chk("midframe rst INT", {15'h0, INT}, 16'h0);
    chk("midframe rst MISO hiz", {15'h0, MISO}, 16'h1);
    spi.SS_n = 1'b1; spi.SCLK = 1'b1; clks(3);
    rst_n = 1'b1; clks(5);
    xfer("post-rst ctrl2", 16'h9100, 8'h00);
    xfer("post-rst whoami", 16'h8F00, 8'h6A);
    xfer("post-rst int1", 16'h8D00, 8'h00);
    xfer("post-rst ptch_h", 16'hA300, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
